// File: rtl/stream_turbo_encoder_pkg.sv
// rtl/stream_turbo_encoder_pkg.sv - shared types and RSC step function for the turbo encoder
// Purpose: termination length, FSM state type, output triple layout and the 13/15 RSC step.
// Ports: none (package).
package stream_turbo_encoder_pkg;

   localparam int MEM = 3;

   typedef enum logic [2:0] {LOAD, ENCODE, TAIL1, TAIL2, DRAIN} enc_state_t;

   typedef struct packed {
      logic sys;
      logic p1;
      logic p2;
      logic tail;
      logic last;
   } enc_triple_t;

   // state = {s1,s2,s3}; returns {next_state, parity}
   function automatic logic [3:0] rsc_step(input logic [2:0] state, input logic u);
      logic a;
      logic p;
      a = u ^ state[1] ^ state[0];
      p = a ^ state[2] ^ state[0];
      return {a, state[2], state[1], p};
   endfunction

endpackage

// File: rtl/stream_turbo_encoder_if.sv
// rtl/stream_turbo_encoder_if.sv - bit-in / triple-out handshake bundle of the turbo encoder
// Purpose: groups the input bit stream, output triple stream and busy flag.
// Ports: in_valid/in_ready/in_bit (bit stream), out_valid/out_ready/out_sys/out_p1/out_p2/
//        out_tail/out_last (triple stream), busy. slave = encoder side, master = source/sink side.
interface stream_turbo_encoder_if;
   logic in_valid;
   logic in_ready;
   logic in_bit;
   logic out_valid;
   logic out_ready;
   logic out_sys;
   logic out_p1;
   logic out_p2;
   logic out_tail;
   logic out_last;
   logic busy;

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last, busy
   );

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last, busy
   );
endinterface

// File: rtl/stream_turbo_encoder_rsc.sv
// rtl/stream_turbo_encoder_rsc.sv - 8-state recursive systematic convolutional encoder (13/15)
// Purpose: one RSC constituent encoder; advances one trellis step when step_en is high.
// Ports: clk, rstn (async active-low), step_en (advance state), term (force u=s2^s3 so the
//        feedback bit is 0), u (input bit) -> sys (effective input bit), p (parity),
//        state ({s1,s2,s3}).
module stream_turbo_encoder_rsc
   import stream_turbo_encoder_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       step_en,
   input  logic       term,
   input  logic       u,
   output logic       sys,
   output logic       p,
   output logic [2:0] state
);

   logic       u_eff;
   logic [3:0] step;

   // Termination input cancels the feedback, driving the register toward 000.
   assign u_eff = term ? (state[1] ^ state[0]) : u;
   assign step  = rsc_step(state, u_eff);
   assign sys   = u_eff;
   assign p     = step[0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= 3'b000;
      end else if (step_en) begin
         state <= step[3:1];
      end
   end

endmodule

// File: rtl/stream_turbo_encoder.sv
// rtl/stream_turbo_encoder.sv - block turbo encoder with QPP interleaver and trellis termination
// Purpose: buffers N information bits, then emits N (sys,p1,p2) triples followed by 2*MEM
//          termination triples; RSC2 reads the buffer in QPP order pi(i)=(F1*i+F2*i*i) mod N.
// Ports: clk, rstn (async active-low), s (stream_turbo_encoder_if.slave: bit input stream,
//        triple output stream, busy).
module stream_turbo_encoder
   import stream_turbo_encoder_pkg::*;
#(
   parameter int N  = 40,
   parameter int F1 = 3,
   parameter int F2 = 10
)
(
   input  logic clk,
   input  logic rstn,
   stream_turbo_encoder_if.slave s
);

   localparam int              AW        = $clog2(N);
   localparam logic [AW:0]     N_EXT     = (AW+1)'(N);
   localparam logic [AW-1:0]   G0        = AW'((F1 + F2) % N);
   localparam logic [AW-1:0]   G_INC     = AW'((2 * F2) % N);
   localparam logic [AW-1:0]   LAST_IDX  = AW'(N - 1);
   localparam logic [AW-1:0]   TAIL_LAST = AW'(MEM - 1);

   enc_state_t    state, state_n;
   logic [AW-1:0] cnt, cnt_n;
   logic [AW-1:0] pi, pi_n;
   logic [AW-1:0] g, g_n;
   logic [AW:0]   pi_sum, g_sum;
   logic          armed;
   logic [N-1:0]  bit_buf;
   enc_triple_t   out_q, out_n;
   logic          out_valid_q, out_valid_n;
   logic          in_acc, out_acc, room;
   logic          step1, step2, term1, term2;
   logic          sys1, sys2, par1, par2;
   logic [2:0]    rsc1_state, rsc2_state;

   // armed keeps in_ready low while reset is asserted and for the first cycle after it.
   assign s.in_ready = armed && (state == LOAD);
   assign in_acc     = s.in_valid && s.in_ready;
   assign out_acc    = out_valid_q && s.out_ready;
   assign room       = !out_valid_q || s.out_ready;

   assign term1 = (state == TAIL1);
   assign term2 = (state == TAIL2);

   // QPP address recurrence: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*F2, all mod N.
   assign pi_sum = {1'b0, pi} + {1'b0, g};
   assign g_sum  = {1'b0, g} + {1'b0, G_INC};

   stream_turbo_encoder_rsc u_rsc1 (
      .clk     (clk),
      .rstn    (rstn),
      .step_en (step1),
      .term    (term1),
      .u       (bit_buf[cnt]),
      .sys     (sys1),
      .p       (par1),
      .state   (rsc1_state)
   );

   stream_turbo_encoder_rsc u_rsc2 (
      .clk     (clk),
      .rstn    (rstn),
      .step_en (step2),
      .term    (term2),
      .u       (bit_buf[pi]),
      .sys     (sys2),
      .p       (par2),
      .state   (rsc2_state)
   );

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pi_n        = pi;
      g_n         = g;
      out_n       = out_q;
      out_valid_n = out_valid_q && !s.out_ready;
      step1       = 1'b0;
      step2       = 1'b0;
      unique case (state)
         LOAD: begin
            if (in_acc) begin
               if (cnt == LAST_IDX) begin
                  state_n = ENCODE;
                  cnt_n   = '0;
                  pi_n    = '0;
                  g_n     = G0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         ENCODE: begin
            if (room) begin
               step1       = 1'b1;
               step2       = 1'b1;
               out_valid_n = 1'b1;
               out_n       = '{sys: sys1, p1: par1, p2: par2, tail: 1'b0, last: 1'b0};
               pi_n        = (pi_sum >= N_EXT) ? AW'(pi_sum - N_EXT) : pi_sum[AW-1:0];
               g_n         = (g_sum >= N_EXT) ? AW'(g_sum - N_EXT) : g_sum[AW-1:0];
               if (cnt == LAST_IDX) begin
                  state_n = TAIL1;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         TAIL1: begin
            if (room) begin
               step1       = 1'b1;
               out_valid_n = 1'b1;
               out_n       = '{sys: sys1, p1: par1, p2: 1'b0, tail: 1'b1, last: 1'b0};
               if (cnt == TAIL_LAST) begin
                  state_n = TAIL2;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         TAIL2: begin
            if (room) begin
               step2       = 1'b1;
               out_valid_n = 1'b1;
               out_n       = '{sys: sys2, p1: 1'b0, p2: par2, tail: 1'b1,
                               last: (cnt == TAIL_LAST)};
               if (cnt == TAIL_LAST) begin
                  state_n = DRAIN;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_acc) begin
               state_n = LOAD;
            end
         end
         default: begin
            state_n = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= LOAD;
         cnt         <= '0;
         pi          <= '0;
         g           <= '0;
         armed       <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         pi          <= pi_n;
         g           <= g_n;
         armed       <= 1'b1;
         out_q       <= out_n;
         out_valid_q <= out_valid_n;
      end
   end

   // Bit buffer has no reset: contents are only read after a full block has been written.
   always_ff @(posedge clk) begin
      if (in_acc) begin
         bit_buf[cnt] <= s.in_bit;
      end
   end

   assign s.out_valid = out_valid_q;
   assign s.out_sys   = out_q.sys;
   assign s.out_p1    = out_q.p1;
   assign s.out_p2    = out_q.p2;
   assign s.out_tail  = out_q.tail;
   assign s.out_last  = out_q.last;
   assign s.busy      = (state != LOAD);

   // Both constituent trellises must be back at the zero state once termination is done.
   a_terminated : assert property (@(posedge clk) disable iff (!rstn)
      (state == DRAIN) |-> (rsc1_state == 3'b000 && rsc2_state == 3'b000));

endmodule

// File: tb/tb_stream_turbo_encoder.sv
// tb/tb_stream_turbo_encoder.sv - scoreboard testbench for the block turbo encoder
module tb_stream_turbo_encoder;

   localparam int N   = 40;
   localparam int F1  = 3;
   localparam int F2  = 10;
   localparam int MEM = 3;

   typedef struct packed {
      logic sys;
      logic p1;
      logic p2;
      logic tail;
      logic last;
   } trip_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   stream_turbo_encoder_if bus ();

   stream_turbo_encoder #(.N(N), .F1(F1), .F2(F2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .s    (bus.slave)
   );

   trip_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    tri_n  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic trip_t cur_triple();
      trip_t t;
      t.sys  = bus.out_sys;
      t.p1   = bus.out_p1;
      t.p2   = bus.out_p2;
      t.tail = bus.out_tail;
      t.last = bus.out_last;
      return t;
   endfunction

   // Reference: each RSC as a feedback delay line a(t) = u ^ a(t-2) ^ a(t-3),
   // parity = a(t) ^ a(t-1) ^ a(t-3); a[k+3] holds a(k), a[0..2] are the zero history.
   function automatic void push_block(input bit blk[N]);
      bit    a1[N+MEM+3];
      bit    a2[N+MEM+3];
      trip_t t;
      int    j;
      bit    u;
      for (int k = 0; k < N + MEM + 3; k++) begin
         a1[k] = 1'b0;
         a2[k] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         j = (F1 * k + F2 * k * k) % N;
         a1[k+3] = blk[k] ^ a1[k+1] ^ a1[k];
         a2[k+3] = blk[j] ^ a2[k+1] ^ a2[k];
         t.sys  = blk[k];
         t.p1   = a1[k+3] ^ a1[k+2] ^ a1[k];
         t.p2   = a2[k+3] ^ a2[k+2] ^ a2[k];
         t.tail = 1'b0;
         t.last = 1'b0;
         exp_q.push_back(t);
      end
      for (int k = N; k < N + MEM; k++) begin
         u = a1[k+1] ^ a1[k];
         a1[k+3] = u ^ a1[k+1] ^ a1[k];
         t = '{sys: u, p1: a1[k+3] ^ a1[k+2] ^ a1[k], p2: 1'b0, tail: 1'b1, last: 1'b0};
         exp_q.push_back(t);
      end
      for (int k = N; k < N + MEM; k++) begin
         u = a2[k+1] ^ a2[k];
         a2[k+3] = u ^ a2[k+1] ^ a2[k];
         t = '{sys: u, p1: 1'b0, p2: a2[k+3] ^ a2[k+2] ^ a2[k], tail: 1'b1,
               last: (k == N + MEM - 1)};
         exp_q.push_back(t);
      end
   endfunction

   // Monitor: compares every accepted triple and checks stability across stalls.
   trip_t held;
   bit    stalled = 1'b0;
   always @(negedge clk) begin
      trip_t act;
      trip_t e;
      if (!rstn) begin
         stalled = 1'b0;
      end else begin
         act = cur_triple();
         if (stalled) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(act), 32'(held));
         end
         stalled = 1'b0;
         if (bus.out_valid) begin
            chk("busy_on_output", 32'(bus.busy), 32'd1);
            if (bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_triple: got 0x%0h expected none", act);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("triple%0d", tri_n), 32'(act), 32'(e));
                  tri_n = (tri_n == N + 2 * MEM - 1) ? 0 : tri_n + 1;
               end
            end else begin
               stalled = 1'b1;
               held    = act;
            end
         end
      end
   end

   task automatic send_block(input bit blk[N], input int nbits, input bit stall, input bit drain);
      int i = 0;
      int guard = 0;
      bit rdy;
      while (i < nbits && guard < 4 * N + 50) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_bit    = blk[i];
         bus.out_ready = 1'b1;
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy && bus.in_valid) i++;
         #1;
         guard++;
      end
      chk("load_accepts", 32'(i), 32'(nbits));
      if (nbits == N) begin
         tri_n = 0;
         push_block(blk);
      end
      if (drain) begin
         guard = 0;
         while (exp_q.size() > 0 && guard < 1000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_bit    = 1'($urandom_range(0, 1));
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            guard++;
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         chk("drain_done", 32'(exp_q.size()), 32'd0);
         @(negedge clk);
         chk("idle_busy", 32'(bus.busy), 32'd0);
         chk("idle_ready", 32'(bus.in_ready), 32'd1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_triple"}, 32'(cur_triple()), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   bit blk[N];

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b1;
      rstn          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

      // all-zero block
      for (int k = 0; k < N; k++) blk[k] = 1'b0;
      send_block(blk, N, 1'b0, 1'b1);

      // single one at index 0, then at index 13 (= pi(1))
      blk[0] = 1'b1;
      send_block(blk, N, 1'b0, 1'b1);
      blk[0]  = 1'b0;
      blk[13] = 1'b1;
      send_block(blk, N, 1'b0, 1'b1);

      // random blocks with and without output back-pressure
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < N; k++) blk[k] = 1'($urandom_range(0, 1));
         send_block(blk, N, (b % 2) == 0, 1'b1);
      end

      // reset after 20 accepted bits discards the partial block
      for (int k = 0; k < N; k++) blk[k] = 1'($urandom_range(0, 1));
      send_block(blk, 20, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check_outputs_zero("partial_reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      chk("no_output_after_reset", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // reset while a triple is pending
      for (int k = 0; k < N; k++) blk[k] = 1'($urandom_range(0, 1));
      send_block(blk, N, 1'b0, 1'b0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("valid_before_reset", 32'(bus.out_valid), 32'd1);
      rstn = 1'b0;
      exp_q.delete();
      #1;
      check_outputs_zero("midblock_reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // next block after reset must encode correctly
      for (int k = 0; k < N; k++) blk[k] = 1'($urandom_range(0, 1));
      send_block(blk, N, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
